// File: rtl/logic_op_pkg.sv
// logic_op_pkg: shared definitions for the selectable bitwise gate pipeline.
//   OP_W        opcode width (fixed at 3)
//   OP_*        opcode values 0..7 (AND, OR, NOT, BUF, NAND, NOR, XOR, XNOR)
//   zero_flag   returns 1 when the supplied vector is all zeros; callers
//               zero-extend narrower vectors to 64 bits before calling.
package logic_op_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_BUF  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd7;

  function automatic logic zero_flag(input logic [63:0] v);
    return (v == 64'd0);
  endfunction

endpackage

// File: rtl/logic_op_core.sv
// logic_op_core: purely combinational bitwise gate selected by opcode.
// Parameters:
//   WIDTH  operand/result width (1..64)
// Ports:
//   a   in  WIDTH  operand A
//   b   in  WIDTH  operand B (ignored by NOT and BUF)
//   op  in  OP_W   gate select
//   y   out WIDTH  gate result
module logic_op_core
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_BUF:  y = a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: selectable bitwise gate with a registered valid/ready output
// stage backed by a one-entry skid buffer (FIFO depth 2, throughput 1/cycle).
// Optional feature macro: LOGIC_OP_PARITY_EN adds out_parity and its storage.
// Parameters:
//   WIDTH  operand/result width (1..64)
//   OP_W   opcode width (3)
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   in_valid    in   producer presents a transaction
//   in_ready    out  transaction accepted this cycle if in_valid (from a flop)
//   in_a, in_b  in   operands
//   in_op       in   gate select
//   out_valid   out  result available
//   out_ready   in   consumer accepts the result
//   out_data    out  gate result
//   out_op      out  opcode echoed with its result
//   out_zero    out  out_data is all zeros
//   out_parity  out  XOR reduction of out_data (LOGIC_OP_PARITY_EN only)
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = logic_op_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OP_W-1:0]  out_op,
`ifdef LOGIC_OP_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_zero
);

  // Stage p0: combinational gate result and its flags
  logic [WIDTH-1:0] res_p0;
  logic             zero_p0;
  logic             accept_p0;
  logic             load_main_p0;

  logic_op_core #(.WIDTH(WIDTH)) u_core (
    .a  (in_a),
    .b  (in_b),
    .op (in_op),
    .y  (res_p0)
  );

  assign zero_p0 = zero_flag(64'(res_p0));

  // Stage p1: main output register and skid register
  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [OP_W-1:0]  op_p1;
  logic             zero_p1;
  logic             skid_vld_p1;
  logic [WIDTH-1:0] skid_data_p1;
  logic [OP_W-1:0]  skid_op_p1;
  logic             skid_zero_p1;
`ifdef LOGIC_OP_PARITY_EN
  logic             par_p1;
  logic             skid_par_p1;
`endif

  assign in_ready     = !skid_vld_p1;
  assign accept_p0    = in_valid && !skid_vld_p1;
  // Main can load whenever it is empty or being drained this cycle.
  assign load_main_p0 = !vld_p1 || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      data_p1      <= '0;
      op_p1        <= '0;
      zero_p1      <= 1'b1;
      skid_vld_p1  <= 1'b0;
      skid_data_p1 <= '0;
      skid_op_p1   <= '0;
      skid_zero_p1 <= 1'b1;
`ifdef LOGIC_OP_PARITY_EN
      par_p1       <= 1'b0;
      skid_par_p1  <= 1'b0;
`endif
    end else if (load_main_p0) begin
      if (skid_vld_p1) begin
        // in_ready is low, so no accept can collide with the skid drain.
        vld_p1      <= 1'b1;
        data_p1     <= skid_data_p1;
        op_p1       <= skid_op_p1;
        zero_p1     <= skid_zero_p1;
        skid_vld_p1 <= 1'b0;
`ifdef LOGIC_OP_PARITY_EN
        par_p1      <= skid_par_p1;
`endif
      end else if (accept_p0) begin
        vld_p1  <= 1'b1;
        data_p1 <= res_p0;
        op_p1   <= in_op;
        zero_p1 <= zero_p0;
`ifdef LOGIC_OP_PARITY_EN
        par_p1  <= ^res_p0;
`endif
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (accept_p0) begin
      // Main is stalled: park the new result in the skid entry.
      skid_vld_p1  <= 1'b1;
      skid_data_p1 <= res_p0;
      skid_op_p1   <= in_op;
      skid_zero_p1 <= zero_p0;
`ifdef LOGIC_OP_PARITY_EN
      skid_par_p1  <= ^res_p0;
`endif
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign out_op     = op_p1;
  assign out_zero   = zero_p1;
`ifdef LOGIC_OP_PARITY_EN
  assign out_parity = par_p1;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: self-checking bench for logic_op_pipe. Expected results
// come from per-opcode truth tables applied bit by bit; ordering and flow
// control come from a queue holding the transactions in flight.
// Honours LOGIC_OP_PARITY_EN the same way as the design.
module tb_logic_op_pipe;

  localparam int WIDTH = 8;
  localparam int OP_W  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OP_W-1:0]  out_op;
  logic             out_zero;
`ifdef LOGIC_OP_PARITY_EN
  logic             out_parity;
`endif

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
`ifdef LOGIC_OP_PARITY_EN
    .out_parity (out_parity),
`endif
    .out_zero   (out_zero)
  );

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  // Truth table per opcode, indexed by {a_bit, b_bit}.
  logic [3:0] tt [8] = '{4'b1000, 4'b1110, 4'b0011, 4'b1100,
                         4'b0111, 4'b0001, 4'b0110, 4'b1001};

  logic [WIDTH-1:0] sweep_exp [8] = '{8'h0A, 8'hAF, 8'h55, 8'hAA,
                                      8'hF5, 8'h50, 8'hA5, 8'h5A};

  function automatic logic [WIDTH-1:0] gate_ref(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [OP_W-1:0]  op);
    logic [WIDTH-1:0] r;
    logic [3:0]       t;
    t = tt[op];
    for (int i = 0; i < WIDTH; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("out_data", 64'(out_data), 64'(q[0].data));
      chk("out_op", 64'(out_op), 64'(q[0].op));
      chk("out_zero", 64'(out_zero), 64'(q[0].data == '0));
`ifdef LOGIC_OP_PARITY_EN
      chk("out_parity", 64'(out_parity), 64'($countones(q[0].data) & 1));
`endif
    end
  endtask

  // One clock: record handshakes seen before the edge, update the model,
  // then compare the DUT against it just after the edge.
  task automatic step();
    logic fire_in, fire_out;
    ent_t e;
    fire_in  = in_valid && in_ready;
    fire_out = out_valid && out_ready;
    e.op     = in_op;
    e.data   = gate_ref(in_a, in_b, in_op);
    @(posedge clk);
    #1;
    if (fire_out && q.size() > 0) void'(q.pop_front());
    if (fire_in) q.push_back(e);
    check_state();
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [OP_W-1:0] op);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
  endtask

  task automatic check_reset_values();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_op", 64'(out_op), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd1);
`ifdef LOGIC_OP_PARITY_EN
    chk("rst_out_parity", 64'(out_parity), 64'd0);
`endif
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    #2;
    check_reset_values();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);

    // Single AND after reset
    out_ready = 1'b1;
    drive(1'b1, 8'hF0, 8'h3C, 3'd0);
    step();
    chk("t1_data", 64'(out_data), 64'h30);
    chk("t1_zero", 64'(out_zero), 64'd0);
    chk("t1_valid", 64'(out_valid), 64'd1);
    drive(1'b0, '0, '0, '0);
    step();

    // Opcode sweep, back-to-back
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hAA, 8'h0F, 3'(i));
      step();
      chk($sformatf("sweep_%0d", i), 64'(out_data), 64'(sweep_exp[i]));
    end
    drive(1'b0, '0, '0, '0);
    step();

    // Back-pressure into the skid entry
    out_ready = 1'b0;
    drive(1'b1, 8'hFF, 8'hFF, 3'd6);
    step();
    drive(1'b1, 8'h01, 8'h02, 3'd1);
    step();
    drive(1'b0, '0, '0, '0);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("bp_hold_data", 64'(out_data), 64'h00);
    chk("bp_hold_zero", 64'(out_zero), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_second", 64'(out_data), 64'h03);
    step();

    // Reset with both entries full
    out_ready = 1'b0;
    drive(1'b1, 8'h12, 8'h34, 3'd6);
    step();
    drive(1'b1, 8'h55, 8'h0F, 3'd1);
    step();
    drive(1'b0, '0, '0, '0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values();
    q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rel2_in_ready", 64'(in_ready), 64'd1);
    chk("rel2_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) step();

`ifdef LOGIC_OP_PARITY_EN
    drive(1'b1, 8'h07, 8'h00, 3'd3);
    step();
    chk("par_07", 64'(out_parity), 64'd1);
    drive(1'b1, 8'h03, 8'h00, 3'd3);
    step();
    chk("par_03", 64'(out_parity), 64'd0);
    drive(1'b0, '0, '0, '0);
    step();
`endif

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 3) != 0, WIDTH'($urandom), WIDTH'($urandom),
            OP_W'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    // Drain
    drive(1'b0, '0, '0, '0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
